fft_sample_loader: RTL and testbench

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

---
 rtl/fft_sample_loader_pkg.sv | 14 +
 rtl/fft_valid_delay.sv | 24 ++
 rtl/fft_sample_loader.sv | 133 +++++++++++++
 tb/tb_fft_sample_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sample_loader_pkg.sv
// Shared constants and state encoding for the FFT sample loader.
// The loader gathers 8 complex samples and launches them as one parallel frame.
package fft_sample_loader_pkg;

  localparam int NFFT        = 8;
  localparam int NFFT_BITS   = 3;
  localparam int FFT_LATENCY = 4;

  typedef enum logic {
    FILL   = 1'b0,
    LAUNCH = 1'b1
  } state_t;

endpackage

// File: rtl/fft_valid_delay.sv
// Fixed-depth shift register for the FFT result-valid strobe.
// Each stage is independent, so back-to-back strobes are each delivered.
module fft_valid_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_sample_loader.sv
// Collects complex samples into a fill bank and launches full 8-sample frames
// into a stable output bank, with early-s_last abort and a delayed result strobe.
module fft_sample_loader
  import fft_sample_loader_pkg::*;
#(
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 8,
  parameter int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_real,
  input  logic [DATA_WIDTH-1:0] s_imag,
  input  logic                  s_last,
  output logic                  fft_en,
  output logic [DATA_WIDTH-1:0] out0_real,
  output logic [DATA_WIDTH-1:0] out0_imag,
  output logic [DATA_WIDTH-1:0] out1_real,
  output logic [DATA_WIDTH-1:0] out1_imag,
  output logic [DATA_WIDTH-1:0] out2_real,
  output logic [DATA_WIDTH-1:0] out2_imag,
  output logic [DATA_WIDTH-1:0] out3_real,
  output logic [DATA_WIDTH-1:0] out3_imag,
  output logic [DATA_WIDTH-1:0] out4_real,
  output logic [DATA_WIDTH-1:0] out4_imag,
  output logic [DATA_WIDTH-1:0] out5_real,
  output logic [DATA_WIDTH-1:0] out5_imag,
  output logic [DATA_WIDTH-1:0] out6_real,
  output logic [DATA_WIDTH-1:0] out6_imag,
  output logic [DATA_WIDTH-1:0] out7_real,
  output logic [DATA_WIDTH-1:0] out7_imag,
  output logic                  res_valid,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);

  // Handshake: a sample transfers on a rising clk edge where s_valid and
  // s_ready are both 1; s_ready only drops while in reset.

  localparam logic [NFFT_BITS-1:0] LAST_IDX = NFFT_BITS'(NFFT - 1);

  state_t                 state;
  logic [NFFT_BITS-1:0]   idx;
  logic [DATA_WIDTH-1:0]  fill_re [NFFT];
  logic [DATA_WIDTH-1:0]  fill_im [NFFT];
  logic [DATA_WIDTH-1:0]  out_re  [NFFT];
  logic [DATA_WIDTH-1:0]  out_im  [NFFT];

  logic accept;
  logic abort;
  logic launch;

  assign accept = s_valid && s_ready;
  assign abort  = accept && s_last && (idx != LAST_IDX);
  assign launch = accept && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      state     <= FILL;
      idx       <= '0;
      fft_en    <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < NFFT; i++) begin
        fill_re[i] <= '0;
        fill_im[i] <= '0;
        out_re[i]  <= '0;
        out_im[i]  <= '0;
      end
    end else begin
      // s_ready is the synchronized release of the asynchronous reset.
      s_ready   <= 1'b1;
      fft_en    <= launch;
      frame_err <= abort;

      case (state)
        FILL:    state <= launch ? LAUNCH : FILL;
        LAUNCH:  state <= FILL;
        default: state <= FILL;
      endcase

      if (abort) begin
        idx <= '0;
      end else if (accept) begin
        fill_re[idx] <= s_real;
        fill_im[idx] <= s_imag;
        if (launch) begin
          // The 8th sample bypasses the fill bank so the frame lands in one edge.
          for (int i = 0; i < NFFT - 1; i++) begin
            out_re[i] <= fill_re[i];
            out_im[i] <= fill_im[i];
          end
          out_re[NFFT-1] <= s_real;
          out_im[NFFT-1] <= s_imag;
          frame_cnt      <= frame_cnt + 16'd1;
          idx            <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  fft_valid_delay #(
    .DEPTH(FFT_LATENCY)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fft_en),
    .q     (res_valid)
  );

  assign out0_real = out_re[0];
  assign out0_imag = out_im[0];
  assign out1_real = out_re[1];
  assign out1_imag = out_im[1];
  assign out2_real = out_re[2];
  assign out2_imag = out_im[2];
  assign out3_real = out_re[3];
  assign out3_imag = out_im[3];
  assign out4_real = out_re[4];
  assign out4_imag = out_im[4];
  assign out5_real = out_re[5];
  assign out5_imag = out_im[5];
  assign out6_real = out_re[6];
  assign out6_imag = out_im[6];
  assign out7_real = out_re[7];
  assign out7_imag = out_im[7];

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: reference model plus frame scoreboard,
// a table-driven single frame and hand-written streaming/abort/gap/reset sequences.
module tb_fft_sample_loader;
  import fft_sample_loader_pkg::*;

  localparam int W  = 16;
  localparam int BW = NFFT * 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [W-1:0] s_real = '0;
  logic [W-1:0] s_imag = '0;
  logic         s_ready, fft_en, res_valid, frame_err;
  logic [15:0]  frame_cnt;
  logic [W-1:0] out0_real, out0_imag, out1_real, out1_imag, out2_real, out2_imag;
  logic [W-1:0] out3_real, out3_imag, out4_real, out4_imag, out5_real, out5_imag;
  logic [W-1:0] out6_real, out6_imag, out7_real, out7_imag;
  logic [BW-1:0] dut_bank;

  int checks = 0;
  int failures = 0;
  int n_launch = 0;
  int n_res = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_sample_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last), .fft_en(fft_en),
    .out0_real(out0_real), .out0_imag(out0_imag), .out1_real(out1_real), .out1_imag(out1_imag),
    .out2_real(out2_real), .out2_imag(out2_imag), .out3_real(out3_real), .out3_imag(out3_imag),
    .out4_real(out4_real), .out4_imag(out4_imag), .out5_real(out5_real), .out5_imag(out5_imag),
    .out6_real(out6_real), .out6_imag(out6_imag), .out7_real(out7_real), .out7_imag(out7_imag),
    .res_valid(res_valid), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // Slot k occupies dut_bank[k*32 +: 32] as {real, imag}.
  assign dut_bank = {out7_real, out7_imag, out6_real, out6_imag, out5_real, out5_imag,
                     out4_real, out4_imag, out3_real, out3_imag, out2_real, out2_imag,
                     out1_real, out1_imag, out0_real, out0_imag};

  function automatic void chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] slot_re(input int k);
    return dut_bank[k*2*W+W +: W];
  endfunction

  function automatic logic [W-1:0] slot_im(input int k);
    return dut_bank[k*2*W +: W];
  endfunction

  // ---------------- reference model ----------------
  logic [2*W-1:0] m_fill [NFFT];
  logic [2:0]     m_idx = '0;
  logic           m_ready = 1'b0;
  logic           exp_fft = 1'b0;
  logic           exp_err = 1'b0;
  logic [FFT_LATENCY-1:0] res_pipe = '0;
  logic [15:0]    exp_cnt = '0;
  logic [BW-1:0]  exp_q[$];
  logic [BW-1:0]  held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx = '0; m_ready = 1'b0; exp_fft = 1'b0; exp_err = 1'b0;
      res_pipe = '0; exp_cnt = '0;
      exp_q.delete();
    end else begin
      logic [BW-1:0] frame;
      res_pipe = {res_pipe[FFT_LATENCY-2:0], exp_fft};
      exp_fft = 1'b0;
      exp_err = 1'b0;
      if (s_valid && m_ready) begin
        if (s_last && m_idx != 3'd7) begin
          exp_err = 1'b1;
          m_idx = '0;
        end else begin
          m_fill[m_idx] = {s_real, s_imag};
          if (m_idx == 3'd7) begin
            for (int i = 0; i < NFFT; i++) frame[i*2*W +: 2*W] = m_fill[i];
            exp_q.push_back(frame);
            exp_fft = 1'b1;
            exp_cnt = exp_cnt + 16'd1;
            m_idx = '0;
          end else begin
            m_idx = m_idx + 3'd1;
          end
        end
      end
      m_ready = 1'b1;
    end
  end

  // ---------------- per-cycle monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) held = '0;
    if (fft_en) begin
      n_launch++;
      if (exp_q.size() > 0) held = exp_q.pop_front();
    end
    if (res_valid) n_res++;
    if (frame_err) n_err++;
    chk("s_ready", BW'(s_ready), BW'(m_ready));
    chk("fft_en", BW'(fft_en), BW'(exp_fft));
    chk("frame_err", BW'(frame_err), BW'(exp_err));
    chk("res_valid", BW'(res_valid), BW'(res_pipe[FFT_LATENCY-1]));
    chk("frame_cnt", BW'(frame_cnt), BW'(exp_cnt));
    chk("bank", dut_bank, held);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    s_valid = 1'b1; s_real = re; s_imag = im; s_last = last;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
    logic [W-1:0] exp_re;
    logic [W-1:0] exp_im;
  } vec_t;

  vec_t          tbl [NFFT];
  logic [W-1:0]  sv_re [NFFT];
  logic [W-1:0]  sv_im [NFFT];

  initial begin
    for (int k = 0; k < NFFT; k++) begin
      tbl[k].re     = W'(k * 256);
      tbl[k].im     = W'(-(k * 256));
      tbl[k].last   = (k == NFFT - 1);
      tbl[k].exp_re = W'(k << 8);
      tbl[k].exp_im = W'(0) - W'(k << 8);
    end

    // Reset held for 3 cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", BW'(s_ready), '0);
    chk("rst_fft_en", BW'(fft_en), '0);
    chk("rst_res_valid", BW'(res_valid), '0);
    chk("rst_frame_cnt", BW'(frame_cnt), '0);
    chk("rst_bank", dut_bank, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", BW'(s_ready), BW'(1));

    // Single frame from the table.
    for (int k = 0; k < NFFT; k++) begin
      send(tbl[k].re, tbl[k].im, tbl[k].last);
      chk("single_fft_en", BW'(fft_en), BW'(k == NFFT - 1));
    end
    for (int k = 0; k < NFFT; k++) begin
      chk("single_slot_re", BW'(slot_re(k)), BW'(tbl[k].exp_re));
      chk("single_slot_im", BW'(slot_im(k)), BW'(tbl[k].exp_im));
    end
    idle(3);
    chk("single_res_early", BW'(res_valid), '0);
    idle(1);
    chk("single_res_valid", BW'(res_valid), BW'(1));
    idle(4);
    chk("single_frame_cnt", BW'(frame_cnt), BW'(1));

    // Streaming: 24 back-to-back samples; frame 2 ends with s_last=0.
    for (int k = 0; k < 3 * NFFT; k++) begin
      send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), (k == 7 || k == 23));
    end
    idle(8);
    chk("stream_launches", BW'(n_launch), BW'(4));
    chk("stream_res", BW'(n_res), BW'(4));

    // Early s_last on the 5th sample, then a full frame.
    for (int k = 0; k < 4; k++) send(W'($urandom_range(0, 65535)), W'(k), 1'b0);
    send(16'h5555, 16'haaaa, 1'b1);
    chk("abort_err", BW'(frame_err), BW'(1));
    chk("abort_no_launch", BW'(fft_en), '0);
    for (int k = 0; k < NFFT; k++) begin
      sv_re[k] = W'($urandom_range(0, 65535));
      sv_im[k] = W'($urandom_range(0, 65535));
      send(sv_re[k], sv_im[k], k == NFFT - 1);
    end
    chk("abort_slot0_re", BW'(slot_re(0)), BW'(sv_re[0]));
    chk("abort_slot0_im", BW'(slot_im(0)), BW'(sv_im[0]));
    idle(8);

    // Gapped input.
    for (int k = 0; k < NFFT; k++) begin
      sv_re[k] = W'($urandom_range(0, 65535));
      sv_im[k] = W'($urandom_range(0, 65535));
      send(sv_re[k], sv_im[k], 1'b0);
      if (k != NFFT - 1) begin
        idle($urandom_range(1, 2));
        chk("gap_no_launch", BW'(fft_en), '0);
      end
    end
    for (int k = 0; k < NFFT; k++) begin
      chk("gap_slot_re", BW'(slot_re(k)), BW'(sv_re[k]));
      chk("gap_slot_im", BW'(slot_im(k)), BW'(sv_im[k]));
    end
    idle(8);

    // Reset after 4 samples, then 8 fresh samples.
    for (int k = 0; k < 4; k++) send(W'(16'h1000 + k), W'(16'h2000 + k), 1'b0);
    rst_n = 1'b0;
    idle(3);
    chk("midrst_fft_en", BW'(fft_en), '0);
    chk("midrst_frame_err", BW'(frame_err), '0);
    chk("midrst_bank", dut_bank, '0);
    rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < NFFT; k++) begin
      sv_re[k] = W'($urandom_range(0, 65535));
      sv_im[k] = W'($urandom_range(0, 65535));
      send(sv_re[k], sv_im[k], k == NFFT - 1);
    end
    chk("midrst_frame_cnt", BW'(frame_cnt), BW'(1));
    for (int k = 0; k < NFFT; k++) begin
      chk("midrst_slot_re", BW'(slot_re(k)), BW'(sv_re[k]));
      chk("midrst_slot_im", BW'(slot_im(k)), BW'(sv_im[k]));
    end
    idle(8);

    chk("total_launches", BW'(n_launch), BW'(7));
    chk("total_res", BW'(n_res), BW'(7));
    chk("total_err", BW'(n_err), BW'(1));
    chk("queue_drained", BW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
